// File: rtl/bulk_in_scheduler.sv
// Shares the transactor's single bulk-IN channel between NUM_SRC endpoint sources.
// Binds the addressed source for one packet, caps the packet at MAX_PKT, and aborts cleanly.
module bulk_in_scheduler #(
   parameter int                   NUM_SRC   = 2,
   parameter logic [4*NUM_SRC-1:0] ENDPOINTS = 8'h21,
   parameter int                   MAX_PKT   = 512
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   blk_start_i,
   input  logic                   blk_cycle_i,
   input  logic [3:0]             blk_endpt_i,
   input  logic                   blk_error_i,
   output logic                   blk_in_ready_o,
   input  logic [NUM_SRC-1:0]     src_ready_i,
   input  logic [NUM_SRC-1:0]     src_tvalid_i,
   output logic [NUM_SRC-1:0]     src_tready_o,
   input  logic [NUM_SRC-1:0]     src_tlast_i,
   input  logic [8*NUM_SRC-1:0]   src_tdata_i,
   output logic                   m_tvalid_o,
   input  logic                   m_tready_i,
   output logic                   m_tlast_o,
   output logic [7:0]             m_tdata_o,
   output logic [NUM_SRC-1:0]     sel_o,
   output logic                   busy_o,
   output logic                   trunc_o
);

   localparam int               CNT_W    = $clog2(MAX_PKT) + 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_PKT - 1);

   typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

   state_t             state, state_next;
   logic [CNT_W-1:0]   count, count_next;
   logic [NUM_SRC-1:0] sel, sel_next;
   logic [NUM_SRC-1:0] match_sel;
   logic               match_hit;
   logic               trunc, trunc_next;
   logic               in_ready;
   logic               in_xfer, abort, beat, last_beat;
   logic               bound_valid, bound_last;
   logic [7:0]         bound_data;

   // Downward scan so the lowest matching index is the one left standing.
   always_comb begin
      match_hit = 1'b0;
      match_sel = '0;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (ENDPOINTS[4*i +: 4] == blk_endpt_i) begin
            match_hit    = 1'b1;
            match_sel    = '0;
            match_sel[i] = 1'b1;
         end
      end
   end

   always_comb begin
      bound_valid = 1'b0;
      bound_last  = 1'b0;
      bound_data  = 8'h00;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (sel[i]) begin
            bound_valid = src_tvalid_i[i];
            bound_last  = src_tlast_i[i];
            bound_data  = src_tdata_i[8*i +: 8];
         end
      end
   end

   // An abort or a reset in progress must not let any byte leave the source.
   assign in_xfer   = (state == XFER) && !reset;
   assign abort     = blk_error_i || !blk_cycle_i;
   assign last_beat = bound_last || (count == LAST_CNT);

   assign m_tvalid_o   = in_xfer && !abort && bound_valid;
   assign m_tlast_o    = in_xfer && last_beat;
   assign m_tdata_o    = in_xfer ? bound_data : 8'h00;
   assign src_tready_o = (in_xfer && !abort && m_tready_i) ? sel : '0;
   assign beat         = m_tvalid_o && m_tready_i;

   always_comb begin
      state_next = state;
      count_next = count;
      sel_next   = sel;
      trunc_next = 1'b0;
      case (state)
         IDLE: begin
            if (blk_start_i && match_hit) begin
               state_next = XFER;
               count_next = '0;
               sel_next   = match_sel;
            end
         end
         XFER: begin
            if (abort) begin
               state_next = IDLE;
               sel_next   = '0;
            end else if (beat) begin
               count_next = count + 1'b1;
               if (last_beat) begin
                  state_next = DONE;
                  trunc_next = !bound_last;
               end
            end
         end
         DONE: begin
            if (blk_error_i || !blk_cycle_i) begin
               state_next = IDLE;
               sel_next   = '0;
            end
         end
         default: begin
            state_next = IDLE;
            sel_next   = '0;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= IDLE;
         count    <= '0;
         sel      <= '0;
         trunc    <= 1'b0;
         in_ready <= 1'b0;
      end else begin
         state    <= state_next;
         count    <= count_next;
         sel      <= sel_next;
         trunc    <= trunc_next;
         in_ready <= match_hit && |(src_ready_i & match_sel);
      end
   end

   assign blk_in_ready_o = in_ready;
   assign sel_o          = sel;
   assign busy_o         = (state != IDLE);
   assign trunc_o        = trunc;

endmodule

// File: tb/tb_bulk_in_scheduler.sv
// Directed bench for bulk_in_scheduler: endpoint-readiness vector table plus
// packet, truncation, abort, unmapped-endpoint, backpressure and reset sequences.
module tb_bulk_in_scheduler;

   logic        clock;
   logic        reset;
   logic        blk_start, blk_cycle, blk_error;
   logic [3:0]  blk_endpt;
   logic        blk_in_ready;
   logic [1:0]  src_ready, src_tvalid, src_tready, src_tlast;
   logic [15:0] src_tdata;
   logic        m_tvalid, m_tready, m_tlast;
   logic [7:0]  m_tdata;
   logic [1:0]  sel;
   logic        busy, trunc;

   bulk_in_scheduler #(.NUM_SRC(2), .ENDPOINTS(8'h21), .MAX_PKT(512)) dut (
      .clock(clock), .reset(reset),
      .blk_start_i(blk_start), .blk_cycle_i(blk_cycle), .blk_endpt_i(blk_endpt),
      .blk_error_i(blk_error), .blk_in_ready_o(blk_in_ready),
      .src_ready_i(src_ready), .src_tvalid_i(src_tvalid), .src_tready_o(src_tready),
      .src_tlast_i(src_tlast), .src_tdata_i(src_tdata),
      .m_tvalid_o(m_tvalid), .m_tready_i(m_tready), .m_tlast_o(m_tlast),
      .m_tdata_o(m_tdata), .sel_o(sel), .busy_o(busy), .trunc_o(trunc)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   int checks = 0;
   int errors = 0;

   // Source FIFO model: read pointer and end-of-packet position per source.
   int ptr[2];
   int endp[2];
   int cur_src;
   logic [1:0] exp_sel;
   int nbeat, last_seen, ntrunc, bad, stray;
   logic [7:0] first_data;

   function automatic logic [7:0] byte_at(input int s, input int p);
      return 8'((p * 7 + s * 85) & 255);
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic drive_src();
      for (int s = 0; s < 2; s++) begin
         src_tvalid[s]        = (ptr[s] < endp[s]);
         src_tlast[s]         = (ptr[s] == endp[s] - 1);
         src_tdata[8*s +: 8]  = byte_at(s, ptr[s]);
      end
   endtask

   task automatic clear_stats();
      nbeat = 0; last_seen = 0; ntrunc = 0; bad = 0; stray = 0; first_data = 8'h00;
   endtask

   // One clock: observe at the falling edge, advance the source model after the rising edge.
   task automatic cyc();
      logic [1:0] take;
      @(negedge clock);
      take = src_tready & src_tvalid;
      if ((src_tready & ~exp_sel) != 2'b00) stray++;
      if (m_tvalid && m_tready) begin
         nbeat++;
         if (cur_src < 0) bad++;
         else if (m_tdata !== byte_at(cur_src, ptr[cur_src]) || !take[cur_src]) bad++;
         if (nbeat == 1) first_data = m_tdata;
         if (m_tlast) last_seen = nbeat;
      end else if (take != 2'b00) begin
         bad++;
      end
      if (trunc) ntrunc++;
      @(posedge clock);
      #1;
      for (int s = 0; s < 2; s++) if (take[s]) ptr[s]++;
      drive_src();
   endtask

   task automatic xact(input string nm, input logic [3:0] ep, input int src, input int err_beat,
                       input bit rnd, input int exp_beats, input int exp_trunc);
      int n;
      cur_src = src;
      exp_sel = (src >= 0) ? 2'(1 << src) : 2'b00;
      clear_stats();
      blk_endpt = ep; blk_cycle = 1'b1; blk_start = 1'b1; m_tready = 1'b0;
      cyc();
      blk_start = 1'b0;
      chk({nm, " sel"}, 32'(sel), 32'(exp_sel));
      chk({nm, " busy"}, 32'(busy), (src >= 0) ? 32'd1 : 32'd0);
      n = 0;
      while (n < 2000) begin
         m_tready  = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         blk_error = (err_beat > 0) && (nbeat == err_beat - 1);
         cyc();
         n++;
         if (blk_error) break;
         if (last_seen != 0) break;
         if (src < 0 && n >= 5) break;
      end
      m_tready = 1'b0;
      chk({nm, " bounded"}, 32'(n < 2000), 32'd1);
      if (blk_error) begin
         blk_error = 1'b0;
         chk({nm, " abort busy"}, 32'(busy), 32'd0);
         chk({nm, " abort sel"}, 32'(sel), 32'd0);
      end else if (src >= 0) begin
         cyc();
         cyc();
         chk({nm, " done sel"}, 32'(sel), 32'(exp_sel));
         chk({nm, " done busy"}, 32'(busy), 32'd1);
         chk({nm, " done tvalid"}, 32'(m_tvalid), 32'd0);
         blk_cycle = 1'b0;
         cyc();
         chk({nm, " idle sel"}, 32'(sel), 32'd0);
         chk({nm, " idle busy"}, 32'(busy), 32'd0);
         chk({nm, " last pos"}, 32'(last_seen), 32'(exp_beats));
      end
      blk_cycle = 1'b0;
      chk({nm, " beats"}, 32'(nbeat), 32'(exp_beats));
      chk({nm, " trunc"}, 32'(ntrunc), 32'(exp_trunc));
      chk({nm, " data"}, 32'(bad), 32'd0);
      chk({nm, " stray tready"}, 32'(stray), 32'd0);
      cyc();
   endtask

   typedef struct {
      logic [3:0] ep;
      logic [1:0] rdy;
      logic       exp;
   } vec_t;

   vec_t vecs[8];
   int   start_ptr;

   initial begin
      vecs[0] = '{ep: 4'd1, rdy: 2'b01, exp: 1'b1};
      vecs[1] = '{ep: 4'd1, rdy: 2'b10, exp: 1'b0};
      vecs[2] = '{ep: 4'd2, rdy: 2'b10, exp: 1'b1};
      vecs[3] = '{ep: 4'd2, rdy: 2'b01, exp: 1'b0};
      vecs[4] = '{ep: 4'd3, rdy: 2'b11, exp: 1'b0};
      vecs[5] = '{ep: 4'd0, rdy: 2'b11, exp: 1'b0};
      vecs[6] = '{ep: 4'd2, rdy: 2'b11, exp: 1'b1};
      vecs[7] = '{ep: 4'd1, rdy: 2'b00, exp: 1'b0};

      reset = 1'b1; blk_start = 1'b0; blk_cycle = 1'b0; blk_error = 1'b0; blk_endpt = 4'd0;
      src_ready = 2'b11; m_tready = 1'b1;
      ptr[0] = 0; ptr[1] = 0; endp[0] = 0; endp[1] = 0;
      cur_src = -1; exp_sel = 2'b00;
      drive_src();
      repeat (2) @(posedge clock);
      #1;
      chk("reset blk_in_ready", 32'(blk_in_ready), 32'd0);
      chk("reset sel", 32'(sel), 32'd0);
      chk("reset busy", 32'(busy), 32'd0);
      chk("reset trunc", 32'(trunc), 32'd0);
      chk("reset tvalid", 32'(m_tvalid), 32'd0);
      chk("reset tready", 32'(src_tready), 32'd0);
      chk("reset tdata", 32'(m_tdata), 32'd0);
      reset = 1'b0; m_tready = 1'b0;
      cyc();

      for (int i = 0; i < 8; i++) begin
         blk_endpt = vecs[i].ep;
         src_ready = vecs[i].rdy;
         cyc();
         chk($sformatf("vec%0d blk_in_ready", i), 32'(blk_in_ready), 32'(vecs[i].exp));
      end

      // T1: readiness latency, then a 10-byte packet from source 1 (EP2).
      blk_endpt = 4'd0; src_ready = 2'b00;
      cyc();
      blk_endpt = 4'd2; src_ready = 2'b10;
      #1;
      chk("t1 ready before edge", 32'(blk_in_ready), 32'd0);
      cyc();
      chk("t1 ready after edge", 32'(blk_in_ready), 32'd1);
      endp[1] = ptr[1] + 10; drive_src();
      xact("t1", 4'd2, 1, 0, 1'b0, 10, 0);

      // T2: 600-byte source packet is cut at 512, remainder follows.
      endp[0] = ptr[0] + 600; drive_src();
      xact("t2a", 4'd1, 0, 0, 1'b0, 512, 1);
      xact("t2b", 4'd1, 0, 0, 1'b0, 88, 0);

      // T3: error on beat 5 of 20, retry resumes with byte 5.
      start_ptr = ptr[0];
      endp[0] = ptr[0] + 20; drive_src();
      xact("t3a", 4'd1, 0, 5, 1'b0, 4, 0);
      chk("t3 consumed", 32'(ptr[0] - start_ptr), 32'd4);
      xact("t3b", 4'd1, 0, 0, 1'b0, 16, 0);
      chk("t3 resume byte", 32'(first_data), 32'(byte_at(0, start_ptr + 4)));

      // T4: unmapped endpoint never binds.
      src_ready = 2'b11; endp[0] = ptr[0] + 8; endp[1] = ptr[1] + 8; drive_src();
      xact("t4", 4'd3, -1, 0, 1'b0, 0, 0);
      chk("t4 blk_in_ready", 32'(blk_in_ready), 32'd0);
      endp[0] = ptr[0]; endp[1] = ptr[1]; drive_src();

      // T5: random backpressure on a 64-byte packet.
      endp[1] = ptr[1] + 64; drive_src();
      xact("t5", 4'd2, 1, 0, 1'b1, 64, 0);

      // T6: reset mid-transfer, then a fresh bind picks up the remaining bytes.
      start_ptr = ptr[0];
      src_ready = 2'b01;
      endp[0] = ptr[0] + 30; drive_src();
      cur_src = 0; exp_sel = 2'b01; clear_stats();
      blk_endpt = 4'd1; blk_cycle = 1'b1; blk_start = 1'b1;
      cyc();
      blk_start = 1'b0; m_tready = 1'b1;
      repeat (3) cyc();
      chk("t6 beats before reset", 32'(nbeat), 32'd3);
      reset = 1'b1;
      cyc();
      chk("t6 consumed", 32'(ptr[0] - start_ptr), 32'd3);
      chk("t6 tready", 32'(src_tready), 32'd0);
      chk("t6 tvalid", 32'(m_tvalid), 32'd0);
      chk("t6 tlast", 32'(m_tlast), 32'd0);
      chk("t6 sel", 32'(sel), 32'd0);
      chk("t6 busy", 32'(busy), 32'd0);
      chk("t6 blk_in_ready", 32'(blk_in_ready), 32'd0);
      chk("t6 trunc", 32'(trunc), 32'd0);
      chk("t6 data", 32'(bad), 32'd0);
      reset = 1'b0; blk_cycle = 1'b0; m_tready = 1'b0;
      cyc();
      xact("t6b", 4'd1, 0, 0, 1'b0, 27, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
